// File: rtl/exu_div_ctrl_pkg.sv
// Shared definitions for the divider controller: one-hot op codes and FSM states.
// The op encoding matches what exu_div expects on its op_i port.
package exu_div_ctrl_pkg;

  localparam logic [3:0] DIV_OP_DIV  = 4'b0001;
  localparam logic [3:0] DIV_OP_DIVU = 4'b0010;
  localparam logic [3:0] DIV_OP_REM  = 4'b0100;
  localparam logic [3:0] DIV_OP_REMU = 4'b1000;

  typedef enum logic [3:0] {
    DIVC_STATE_IDLE  = 4'b0001,
    DIVC_STATE_ISSUE = 4'b0010,
    DIVC_STATE_RESP  = 4'b0100,
    DIVC_STATE_DRAIN = 4'b1000
  } divc_state_e;

endpackage

// File: rtl/exu_div_rr_arb.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a tie
// and flips to the other requester whenever a grant is taken.
module exu_div_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic grant0,
  output logic grant1,
  output logic ptr
);

  assign grant0 = en & req0 & (~req1 | ~ptr);
  assign grant1 = en & req1 & (~req0 | ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (take) begin
      ptr <= grant0;
    end
  end

endmodule

// File: rtl/exu_div_ctrl.sv
// Arbitrates two EX-stage requesters onto one iterative divider and returns results
// through a valid/ready writeback port, with a one-entry last-result cache.
module exu_div_ctrl
  import exu_div_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int CACHE_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [3:0]        req0_op_i,
  input  logic [DATA_W-1:0] req0_dividend_i,
  input  logic [DATA_W-1:0] req0_divisor_i,
  input  logic [ADDR_W-1:0] req0_waddr_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [3:0]        req1_op_i,
  input  logic [DATA_W-1:0] req1_dividend_i,
  input  logic [DATA_W-1:0] req1_divisor_i,
  input  logic [ADDR_W-1:0] req1_waddr_i,
  input  logic              flush_i,
  output logic              div_start_o,
  output logic [3:0]        div_op_o,
  output logic [DATA_W-1:0] div_dividend_o,
  output logic [DATA_W-1:0] div_divisor_o,
  output logic [ADDR_W-1:0] div_waddr_o,
  input  logic [DATA_W-1:0] div_result_i,
  input  logic              div_ready_i,
  input  logic              div_busy_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic              wb_src_o,
  output logic              busy_o
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // ready never depends on anything but state, arbitration, flush and reset.

  divc_state_e state, state_nxt;

  logic [3:0]        op_q;
  logic [DATA_W-1:0] dvd_q, dvs_q, wb_data_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              src_q;

  logic              c_vld;
  logic [3:0]        c_op;
  logic [DATA_W-1:0] c_dvd, c_dvs, c_res;

  logic grant0, grant1, rr_ptr, arb_en, hs, hit;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] sel_dvd, sel_dvs;
  logic [ADDR_W-1:0] sel_waddr;

  logic unused_busy;
  assign unused_busy = div_busy_i | rr_ptr;

  assign arb_en = (state == DIVC_STATE_IDLE) & ~flush_i & ~rst;

  exu_div_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .req0   (req0_valid_i),
    .req1   (req1_valid_i),
    .take   (hs),
    .grant0 (grant0),
    .grant1 (grant1),
    .ptr    (rr_ptr)
  );

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign hs           = grant0 | grant1;

  assign sel_op    = grant1 ? req1_op_i       : req0_op_i;
  assign sel_dvd   = grant1 ? req1_dividend_i : req0_dividend_i;
  assign sel_dvs   = grant1 ? req1_divisor_i  : req0_divisor_i;
  assign sel_waddr = grant1 ? req1_waddr_i    : req0_waddr_i;

  // Cache is keyed on the operation only; destination and owner are irrelevant.
  assign hit = (CACHE_EN != 0) & c_vld & (sel_op == c_op) &
               (sel_dvd == c_dvd) & (sel_dvs == c_dvs);

  always_comb begin
    state_nxt = state;
    case (state)
      DIVC_STATE_IDLE:  if (hs) state_nxt = hit ? DIVC_STATE_RESP : DIVC_STATE_ISSUE;
      DIVC_STATE_ISSUE: begin
        if (flush_i)          state_nxt = DIVC_STATE_DRAIN;
        else if (div_ready_i) state_nxt = DIVC_STATE_RESP;
      end
      DIVC_STATE_RESP:  if (wb_ready_i | flush_i) state_nxt = DIVC_STATE_IDLE;
      DIVC_STATE_DRAIN: state_nxt = DIVC_STATE_IDLE;
      default:          state_nxt = DIVC_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= DIVC_STATE_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      waddr_q   <= '0;
      src_q     <= 1'b0;
      wb_data_q <= '0;
      c_vld     <= 1'b0;
      c_op      <= '0;
      c_dvd     <= '0;
      c_dvs     <= '0;
      c_res     <= '0;
    end else begin
      if (state == DIVC_STATE_IDLE && hs) begin
        op_q    <= sel_op;
        dvd_q   <= sel_dvd;
        dvs_q   <= sel_dvs;
        waddr_q <= sel_waddr;
        src_q   <= grant1;
        if (hit) wb_data_q <= c_res;
      end
      // A result arriving together with a flush still refreshes the cache.
      if (state == DIVC_STATE_ISSUE && div_ready_i) begin
        c_vld <= 1'b1;
        c_op  <= op_q;
        c_dvd <= dvd_q;
        c_dvs <= dvs_q;
        c_res <= div_result_i;
        if (!flush_i) wb_data_q <= div_result_i;
      end
    end
  end

  // Start must fall in the ready cycle itself or the divider restarts.
  assign div_start_o    = (state == DIVC_STATE_ISSUE) & ~div_ready_i & ~flush_i & ~rst;
  assign div_op_o       = op_q;
  assign div_dividend_o = dvd_q;
  assign div_divisor_o  = dvs_q;
  assign div_waddr_o    = waddr_q;

  assign wb_valid_o = (state == DIVC_STATE_RESP);
  assign wb_data_o  = wb_data_q;
  assign wb_waddr_o = waddr_q;
  assign wb_src_o   = src_q;
  assign busy_o     = (state != DIVC_STATE_IDLE);

endmodule

// File: tb/tb_exu_div_ctrl.sv
// Bench for exu_div_ctrl: behavioural divider model, directed steps, and a
// writeback scoreboard fed from an expected-result queue.
module tb_exu_div_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [3:0] OP_DIV = 4'b0001, OP_DIVU = 4'b0010, OP_REM = 4'b0100, OP_REMU = 4'b1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
  logic [3:0]    req0_op_i, req1_op_i;
  logic [DW-1:0] req0_dividend_i, req0_divisor_i, req1_dividend_i, req1_divisor_i;
  logic [AW-1:0] req0_waddr_i, req1_waddr_i;
  logic          flush_i, div_start_o, div_ready_i, div_busy_i;
  logic [3:0]    div_op_o;
  logic [DW-1:0] div_dividend_o, div_divisor_o, div_result_i, wb_data_o;
  logic [AW-1:0] div_waddr_o, wb_waddr_o;
  logic          wb_valid_o, wb_ready_i, wb_src_o, busy_o;

  exu_div_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CACHE_EN(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
    .req0_dividend_i(req0_dividend_i), .req0_divisor_i(req0_divisor_i), .req0_waddr_i(req0_waddr_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
    .req1_dividend_i(req1_dividend_i), .req1_divisor_i(req1_divisor_i), .req1_waddr_i(req1_waddr_i),
    .flush_i(flush_i), .div_start_o(div_start_o), .div_op_o(div_op_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o), .div_waddr_o(div_waddr_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i), .div_busy_i(div_busy_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .wb_waddr_o(wb_waddr_o), .wb_src_o(wb_src_o), .busy_o(busy_o)
  );

  int tests = 0;
  int fails = 0;
  logic [DW+AW:0] exp_q[$];
  logic [DW+AW:0] sb_e;
  int start_cycles = 0, start_in_ready = 0, model_aborts = 0, operand_changes = 0;

  function automatic logic [DW-1:0] ref_div(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  return (b == 0) ? '1 : (ovf ? a : DW'($signed(a) / $signed(b)));
      OP_DIVU: return (b == 0) ? '1 : a / b;
      OP_REM:  return (b == 0) ? a : (ovf ? '0 : DW'($signed(a) % $signed(b)));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Divider model: ~35-cycle normal op, 3-cycle divide by zero, aborts when start drops.
  logic          m_busy = 1'b0;
  int            m_cnt;
  logic [3:0]    m_op;
  logic [DW-1:0] m_a, m_b;
  assign div_busy_i = m_busy;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; div_ready_i <= 1'b0; div_result_i <= '0;
    end else begin
      div_ready_i <= 1'b0;
      if (m_busy && !div_start_o) begin
        m_busy <= 1'b0;
        model_aborts <= model_aborts + 1;
      end else if (m_busy) begin
        if ({div_op_o, div_dividend_o, div_divisor_o} != {m_op, m_a, m_b})
          operand_changes <= operand_changes + 1;
        if (m_cnt == 0) begin
          div_ready_i  <= 1'b1;
          div_result_i <= ref_div(m_op, m_a, m_b);
          m_busy       <= 1'b0;
        end else m_cnt <= m_cnt - 1;
      end else if (div_start_o) begin
        m_busy <= 1'b1; m_op <= div_op_o; m_a <= div_dividend_o; m_b <= div_divisor_o;
        m_cnt  <= (div_divisor_o == 0) ? 2 : 34;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (div_start_o) start_cycles++;
      if (div_start_o && div_ready_i) start_in_ready++;
    end
  end

  // Scoreboard: pop on every accepted writeback.
  always @(negedge clk) begin
    if (!rst && wb_valid_o && wb_ready_i) begin
      if (exp_q.size() == 0) check("wb_unexpected", 64'd1, 64'd0);
      else begin
        sb_e = exp_q.pop_front();
        check("wb_data",  64'(wb_data_o),  64'(sb_e[DW-1:0]));
        check("wb_waddr", 64'(wb_waddr_o), 64'(sb_e[DW+AW-1:DW]));
        check("wb_src",   64'(wb_src_o),   64'(sb_e[DW+AW]));
      end
    end
  end

  task automatic drive(input int n, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] wa, input bit expect_wb);
    if (n == 0) begin
      req0_valid_i = 1'b1; req0_op_i = op; req0_dividend_i = a; req0_divisor_i = b; req0_waddr_i = wa;
    end else begin
      req1_valid_i = 1'b1; req1_op_i = op; req1_dividend_i = a; req1_divisor_i = b; req1_waddr_i = wa;
    end
    if (expect_wb) exp_q.push_back({n[0], wa, ref_div(op, a, b)});
  endtask

  // Waits for requester n to be granted, lets the handshake edge pass, then drops valid.
  task automatic wait_hs(input int n);
    int k = 0;
    #1;
    while (!((n == 0) ? req0_ready_o : req1_ready_o) && k < 400) begin
      @(negedge clk); k++;
    end
    check("hs_timeout", 64'(k < 400), 64'd1);
    @(negedge clk);
    if (n == 0) req0_valid_i = 1'b0; else req1_valid_i = 1'b0;
  endtask

  task automatic send(input int n, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [AW-1:0] wa, input bit expect_wb);
    drive(n, op, a, b, wa, expect_wb);
    wait_hs(n);
  endtask

  task automatic wait_done();
    int k = 0;
    while ((exp_q.size() != 0 || busy_o) && k < 400) begin
      @(negedge clk); k++;
    end
    check("done_timeout", 64'(k < 400), 64'd1);
  endtask

  int sc;
  logic [DW-1:0] hold_data;
  logic [AW-1:0] hold_waddr;
  logic          hold_src;

  initial begin
    rst = 1'b1; flush_i = 1'b0; wb_ready_i = 1'b1;
    req0_valid_i = 1'b0; req0_op_i = '0; req0_dividend_i = '0; req0_divisor_i = '0; req0_waddr_i = '0;
    req1_valid_i = 1'b0; req1_op_i = '0; req1_dividend_i = '0; req1_divisor_i = '0; req1_waddr_i = '0;
    repeat (3) @(negedge clk);
    req0_valid_i = 1'b1;
    #1;
    check("rst_req0_ready", 64'(req0_ready_o), 64'd0);
    check("rst_wb_valid",   64'(wb_valid_o),   64'd0);
    check("rst_busy",       64'(busy_o),       64'd0);
    check("rst_start",      64'(div_start_o),  64'd0);
    check("rst_wb_data",    64'(wb_data_o),    64'd0);
    check("rst_div_op",     64'(div_op_o),     64'd0);
    req0_valid_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Simultaneous requests: pointer starts at requester 0.
    drive(0, OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd1, 1'b1);
    drive(1, OP_DIVU, 32'd100,       32'd7, 5'd2, 1'b1);
    #1;
    check("tie_ready0", 64'(req0_ready_o), 64'd1);
    check("tie_ready1", 64'(req1_ready_o), 64'd0);
    wait_hs(0);
    check("issue_start", 64'(div_start_o), 64'd1);
    wait_hs(1);
    wait_done();

    // Miss path, then an identical op from both requesters served from the cache.
    sc = start_cycles;
    send(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1);
    wait_done();
    check("miss_used_div", 64'(start_cycles > sc), 64'd1);
    sc = start_cycles;
    send(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);
    check("hit_latency", 64'(wb_valid_o), 64'd1);
    wait_done();
    send(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1);
    check("hit1_latency", 64'(wb_valid_o), 64'd1);
    wait_done();
    check("hit_no_start", 64'(start_cycles), 64'(sc));

    // Divide by zero.
    send(0, OP_DIVU, 32'd5, 32'd0, 5'd6, 1'b1);
    wait_done();
    send(1, OP_REMU, 32'd5, 32'd0, 5'd7, 1'b1);
    wait_done();
    check("aborts_before_flush", 64'(model_aborts), 64'd0);

    // Flush 10 cycles into ISSUE.
    send(0, OP_DIVU, 32'd1000, 32'd3, 5'd8, 1'b0);
    repeat (9) @(negedge clk);
    check("pre_flush_start", 64'(div_start_o), 64'd1);
    flush_i = 1'b1;
    #1;
    check("flush_start_low", 64'(div_start_o), 64'd0);
    @(negedge clk); flush_i = 1'b0;
    check("drain_busy",  64'(busy_o),      64'd1);
    check("drain_start", 64'(div_start_o), 64'd0);
    @(negedge clk);
    check("post_drain_idle", 64'(busy_o),     64'd0);
    check("flush_no_wb",     64'(wb_valid_o), 64'd0);
    check("flush_abort",     64'(model_aborts), 64'd1);
    send(0, OP_DIVU, 32'd1000, 32'd3, 5'd9, 1'b1);
    wait_done();

    // Writeback back-pressure with requester 1 waiting.
    wb_ready_i = 1'b0;
    send(0, OP_REM, 32'd17, 32'd5, 5'd10, 1'b1);
    drive(1, OP_DIV, 32'd40, 32'd8, 5'd11, 1'b1);
    sc = 0;
    while (!wb_valid_o && sc < 400) begin @(negedge clk); sc++; end
    check("stall_wb_timeout", 64'(sc < 400), 64'd1);
    hold_data = wb_data_o; hold_waddr = wb_waddr_o; hold_src = wb_src_o;
    check("stall_data_val", 64'(hold_data), 64'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(wb_valid_o),   64'd1);
      check("stall_data",  64'(wb_data_o),    64'(hold_data));
      check("stall_waddr", 64'({wb_src_o, wb_waddr_o}), 64'({hold_src, hold_waddr}));
      check("stall_no_grant", 64'(req1_ready_o), 64'd0);
    end
    wb_ready_i = 1'b1;
    wait_hs(1);
    wait_done();

    check("start_in_ready_cycle", 64'(start_in_ready),  64'd0);
    check("operands_unstable",    64'(operand_changes), 64'd0);
    check("total_aborts",         64'(model_aborts),    64'd1);
    check("queue_empty",          64'(exp_q.size()),    64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
